// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, credit-limited IMEM requests, instruction queue
// Optional IF_BYPASS_EN: a response arriving at an empty queue is presented to decode in the same cycle.
module if_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         tag_rd_ptr_q, tag_rd_ptr_d, tag_wr_ptr_q, tag_wr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_d   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tag_q  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tag_d  [FIFO_DEPTH];

  logic credit, accept, rsp_live, bypass, push, pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign imem_req_addr        = fetch_pc_q;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_ptr_d  = tag_rd_ptr_q;
    tag_wr_ptr_d  = tag_wr_ptr_q;
    data_d        = data_q;
    pc_d          = pc_q;
    tag_d         = tag_q;

    // In-flight requests plus buffered entries never exceed the queue size.
    credit         = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C;
    imem_req_valid = (state_q != BOOT) && !redirect_en && credit;
    accept         = imem_req_valid && imem_req_ready;
    rsp_live       = imem_rsp_valid && !redirect_en && (drop_q == '0);
`ifdef IF_BYPASS_EN
    bypass         = rsp_live && (count_q == '0);
`else
    bypass         = 1'b0;
`endif

    inst_valid = 1'b0;
    inst       = NOP;
    inst_pc    = '0;
    if (count_q != '0) begin
      inst_valid = 1'b1;
      inst       = data_q[rd_ptr_q];
      inst_pc    = pc_q[rd_ptr_q];
    end else if (bypass) begin
      inst_valid = 1'b1;
      inst       = imem_rsp_data;
      inst_pc    = tag_q[tag_rd_ptr_q];
    end

    pop  = (count_q != '0) && !stall && !redirect_en;
    push = rsp_live && !(bypass && !stall);

    if (push) begin
      data_d[wr_ptr_q] = imem_rsp_data;
      pc_d[wr_ptr_q]   = tag_q[tag_rd_ptr_q];
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);

    if (accept) begin
      tag_d[tag_wr_ptr_q] = fetch_pc_q;
      tag_wr_ptr_d        = tag_wr_ptr_q + 1'b1;
      fetch_pc_d          = fetch_pc_q + ADDR_WIDTH'(4);
    end
    if (rsp_live) tag_rd_ptr_d = tag_rd_ptr_q + 1'b1;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);

    // Redirect flushes everything; responses still in flight become stale and are dropped.
    if (redirect_en) begin
      fetch_pc_d   = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      drop_d       = outstanding_q - CW'(imem_rsp_valid);
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      tag_rd_ptr_d = '0;
      tag_wr_ptr_d = '0;
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect_en && (drop_d != '0)) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_ptr_q  <= '0;
      tag_wr_ptr_q  <= '0;
      data_q        <= '{default: '0};
      pc_q          <= '{default: '0};
      tag_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_ptr_q  <= tag_rd_ptr_d;
      tag_wr_ptr_q  <= tag_wr_ptr_d;
      data_q        <= data_d;
      pc_q          <= pc_d;
      tag_q         <= tag_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage with an IMEM model and an instruction scoreboard
// Honours IF_BYPASS_EN when computing when an instruction becomes visible.
module tb_if_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  pend_t       pend_q[$];
  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc_n  = 0;
  int          lat    = 1;
  bit          boot;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  if_stage #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    pend_q.delete();
    sb_q.delete();
    exp_addr       = 32'h0;
    boot           = 1'b1;
    imem_rsp_valid = 1'b0;
    #3;
    arst_n = 1'b1;
  endtask

  // One clock cycle: drive the IMEM response, check outputs against the model, then advance.
  task automatic cyc();
    int sb_before;
    bit live, exp_valid, exp_req;
    live = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_q[0].addr ^ 32'h5A5A_0000;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    sb_before = sb_q.size();
    if (imem_rsp_valid && !redirect_en && !pend_q[0].stale) begin
      live = 1'b1;
      sb_q.push_back('{data: imem_rsp_data, pc: pend_q[0].addr});
    end
`ifdef IF_BYPASS_EN
    exp_valid = sb_q.size() > 0;
`else
    exp_valid = sb_before > 0;
`endif
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("inst", inst, sb_q[0].data);
      chk("inst_pc", inst_pc, sb_q[0].pc);
      if (!stall && !redirect_en) void'(sb_q.pop_front());
    end else begin
      chk("inst_empty", inst, NOP);
      chk("inst_pc_empty", inst_pc, 32'h0);
    end
    exp_req = !boot && !redirect_en && ((pend_q.size() + sb_before) < DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_addr);
    if (imem_rsp_valid) void'(pend_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{addr: exp_addr, due: cyc_n + lat, stale: 1'b0});
      exp_addr = exp_addr + 32'd4;
    end
    if (redirect_en) begin
      sb_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_addr = {redirect_pc[31:2], 2'b00};
    end
    if (live && sb_q.size() > DEPTH) chk("queue_overflow", sb_q.size(), DEPTH);
    boot = 1'b0;
    @(posedge clk);
    #2;
    cyc_n++;
  endtask

  initial begin
    arst_n         = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_en    = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    #2;
    do_reset();

    imem_req_ready = 1'b1;
    lat = 1;
    repeat (8) cyc();

    stall = 1'b1;
    repeat (5) cyc();
    stall = 1'b0;
    repeat (6) cyc();

    lat = 3;
    repeat (6) cyc();
    redirect_pc = 32'h0000_0100;
    redirect_en = 1'b1;
    cyc();
    redirect_en = 1'b0;
    repeat (8) cyc();
    redirect_pc = 32'h0000_0103;
    redirect_en = 1'b1;
    cyc();
    redirect_en = 1'b0;
    repeat (6) cyc();

    redirect_pc = 32'h0000_0200;
    redirect_en = 1'b1;
    cyc();
    redirect_pc = 32'h0000_0300;
    cyc();
    redirect_en = 1'b0;
    repeat (8) cyc();

    for (int i = 0; i < 20; i++) begin
      imem_req_ready = (i % 2) == 0;
      cyc();
    end

    imem_req_ready = 1'b1;
    lat = 1;
    redirect_pc = 32'hFFFF_FFF4;
    redirect_en = 1'b1;
    cyc();
    redirect_en = 1'b0;
    repeat (8) cyc();

    for (int i = 0; i < 40; i++) begin
      stall          = ($urandom_range(0, 3) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      lat            = (i < 20) ? 1 : 2;
      cyc();
    end
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    lat            = 1;
    repeat (4) cyc();

    do_reset();
    repeat (8) cyc();

    imem_req_ready = 1'b0;
    repeat (6) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
